cpu_clock_ctrl: RTL and testbench

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

---
 rtl/cpu_clock_ctrl.sv | 106 ++++++++++
 tb/tb_cpu_clock_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// Front-panel CPU clock controller: programmable clock-enable divider with
// RUN / STOP / SINGLE-STEP control and ready-driven wait states.
module cpu_clock_ctrl #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEFAULT_DIV = 25
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             run_req,
   input  logic             stop_req,
   input  logic             step_req,
   input  logic             ready,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_value,
   output logic             ce,
   output logic             running,
   output logic             stepping,
   output logic [WIDTH-1:0] div_cur
);

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_cur_q, div_cur_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             ce_q, ce_d;

   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] pend_next;
   logic             at_end;
   logic             wrap;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_cur_d = div_cur_q;
      ce_d      = 1'b0;

      // A zero divisor would never wrap; treat it as divide-by-one.
      load_val  = (div_value == '0) ? ONE : div_value;
      pend_next = div_load ? load_val : pend_q;
      pend_d    = pend_next;

      at_end = (cnt_q == div_cur_q - ONE);
      wrap   = at_end && ready;

      unique case (state_q)
         ST_STOP: begin
            cnt_d     = '0;
            div_cur_d = pend_next;
            if (!stop_req) begin
               if (run_req)       state_d = ST_RUN;
               else if (step_req) state_d = ST_STEP;
            end
         end
         ST_RUN, ST_STEP: begin
            if (stop_req) begin
               state_d = ST_STOP;
               cnt_d   = '0;
            end else if (wrap) begin
               // Divisor swaps only on a wrap so no period is cut short.
               ce_d      = 1'b1;
               cnt_d     = '0;
               div_cur_d = pend_next;
               if (state_q == ST_STEP) state_d = ST_STOP;
            end else if (!at_end) begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = ST_STOP;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q   <= ST_STOP;
         cnt_q     <= '0;
         ce_q      <= 1'b0;
         div_cur_q <= DIV_RST;
         pend_q    <= DIV_RST;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ce_q      <= ce_d;
         div_cur_q <= div_cur_d;
         pend_q    <= pend_d;
      end
   end

   assign ce       = ce_q;
   assign running  = (state_q == ST_RUN);
   assign stepping = (state_q == ST_STEP);
   assign div_cur  = div_cur_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: the driver queues the expected
// {ce, running, stepping, div_cur} per edge; the monitor pops and compares.
module tb_cpu_clock_ctrl;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic        run_req = 1'b0;
   logic        stop_req = 1'b0;
   logic        step_req = 1'b0;
   logic        ready = 1'b1;
   logic        div_load = 1'b0;
   logic [15:0] div_value = '0;
   logic        ce;
   logic        running;
   logic        stepping;
   logic [15:0] div_cur;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [18:0] exp_q[$];
   string       name_q[$];

   cpu_clock_ctrl #(.WIDTH(16), .DEFAULT_DIV(4)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .run_req  (run_req),
      .stop_req (stop_req),
      .step_req (step_req),
      .ready    (ready),
      .div_load (div_load),
      .div_value(div_value),
      .ce       (ce),
      .running  (running),
      .stepping (stepping),
      .div_cur  (div_cur)
   );

   always #5 clk_in = ~clk_in;

   task automatic cyc(input string nm, input logic r, input logic s, input logic st,
                      input logic rdy, input logic ld, input logic [15:0] v,
                      input logic e_ce, input logic e_run, input logic e_step,
                      input logic [15:0] e_div);
      @(negedge clk_in);
      rst       = 1'b0;
      run_req   = r;
      stop_req  = s;
      step_req  = st;
      ready     = rdy;
      div_load  = ld;
      div_value = v;
      exp_q.push_back({e_ce, e_run, e_step, e_div});
      name_q.push_back(nm);
   endtask

   task automatic idle(input string nm, input logic e_ce, input logic e_run,
                       input logic e_step, input logic [15:0] e_div);
      cyc(nm, 0, 0, 0, 1, 0, 16'd0, e_ce, e_run, e_step, e_div);
   endtask

   task automatic rst_cyc(input string nm);
      @(negedge clk_in);
      rst       = 1'b1;
      run_req   = 1'b0;
      stop_req  = 1'b0;
      step_req  = 1'b0;
      ready     = 1'b1;
      div_load  = 1'b0;
      div_value = '0;
      exp_q.push_back({1'b0, 1'b0, 1'b0, 16'd4});
      name_q.push_back(nm);
   endtask

   initial begin : monitor
      logic [18:0] e;
      logic [18:0] act;
      string       nm;
      forever begin
         @(posedge clk_in);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {ce, running, stepping, div_cur};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL %s: got ce=%0b running=%0b stepping=%0b div_cur=%0d, expected ce=%0b running=%0b stepping=%0b div_cur=%0d",
                        nm, act[18], act[17], act[16], act[15:0], e[18], e[17], e[16], e[15:0]);
            end
         end
      end
   end

   initial begin : driver
      rst_cyc("reset");
      rst_cyc("reset");

      // Free run at the reset divisor
      cyc("run_start", 1, 0, 0, 1, 0, 16'd0, 0, 1, 0, 4);
      for (int i = 1; i <= 12; i++) idle("run_period", (i % 4 == 0), 1, 0, 4);
      cyc("run_stop", 0, 1, 0, 1, 0, 16'd0, 0, 0, 0, 4);

      // Wait states: ready low on edges 2..5 holds the count at its end value
      cyc("wait_start", 1, 0, 0, 1, 0, 16'd0, 0, 1, 0, 4);
      idle("wait_e1", 0, 1, 0, 4);
      for (int i = 2; i <= 5; i++) cyc("wait_hold", 0, 0, 0, 0, 0, 16'd0, 0, 1, 0, 4);
      idle("wait_release", 1, 1, 0, 4);
      for (int i = 7; i <= 10; i++) idle("wait_after", (i == 10), 1, 0, 4);
      cyc("wait_stop", 0, 1, 0, 1, 0, 16'd0, 0, 0, 0, 4);

      // Single step at divisor 3
      cyc("step_load", 0, 0, 0, 1, 1, 16'd3, 0, 0, 0, 3);
      cyc("step_start", 0, 0, 1, 1, 0, 16'd0, 0, 0, 1, 3);
      idle("step_count", 0, 0, 1, 3);
      idle("step_count", 0, 0, 1, 3);
      idle("step_ce", 1, 0, 0, 3);
      for (int i = 0; i < 20; i++) idle("step_quiet", 0, 0, 0, 3);

      // Held step request at divisor 2 repeats every 3 cycles
      cyc("hstep_load", 0, 0, 0, 1, 1, 16'd2, 0, 0, 0, 2);
      for (int i = 0; i < 6; i++)
         cyc("hstep", 0, 0, 1, 1, 0, 16'd0, (i % 3 == 2), 0, (i % 3 != 2), 2);
      idle("hstep_end", 0, 0, 0, 2);

      // Divisor change mid-period waits for the next wrap
      cyc("chg_load4", 0, 0, 0, 1, 1, 16'd4, 0, 0, 0, 4);
      cyc("chg_start", 1, 0, 0, 1, 0, 16'd0, 0, 1, 0, 4);
      for (int i = 1; i <= 4; i++) idle("chg_first", (i == 4), 1, 0, 4);
      cyc("chg_load2", 0, 0, 0, 1, 1, 16'd2, 0, 1, 0, 4);
      idle("chg_old", 0, 1, 0, 4);
      idle("chg_old", 0, 1, 0, 4);
      idle("chg_swap", 1, 1, 0, 2);
      for (int i = 9; i <= 12; i++) idle("chg_new", (i % 2 == 0), 1, 0, 2);
      cyc("chg_stop", 0, 1, 0, 1, 0, 16'd0, 0, 0, 0, 2);

      // Load coinciding with run start; run beats step; stop beats all on a wrap
      cyc("pri_load_run", 1, 0, 1, 1, 1, 16'd4, 0, 1, 0, 4);
      for (int i = 1; i <= 7; i++) idle("pri_run", (i == 4), 1, 0, 4);
      cyc("pri_stop_wrap", 1, 1, 1, 1, 0, 16'd0, 0, 0, 0, 4);
      idle("pri_stopped", 0, 0, 0, 4);
      idle("pri_stopped", 0, 0, 0, 4);
      cyc("pri_restart", 1, 0, 0, 1, 0, 16'd0, 0, 1, 0, 4);
      for (int i = 1; i <= 4; i++) idle("pri_cnt_zero", (i == 4), 1, 0, 4);
      cyc("pri_stop", 0, 1, 0, 1, 0, 16'd0, 0, 0, 0, 4);

      // Zero divisor becomes 1; reset mid-run restores the default
      cyc("div0_load", 0, 0, 0, 1, 1, 16'd0, 0, 0, 0, 1);
      cyc("div0_run", 1, 0, 0, 1, 0, 16'd0, 0, 1, 0, 1);
      for (int i = 0; i < 5; i++) idle("div0_every", 1, 1, 0, 1);
      rst_cyc("mid_reset");
      idle("post_reset", 0, 0, 0, 4);
      cyc("post_reset_run", 1, 0, 0, 1, 0, 16'd0, 0, 1, 0, 4);
      for (int i = 1; i <= 4; i++) idle("post_reset_period", (i == 4), 1, 0, 4);
      cyc("final_stop", 0, 1, 0, 1, 0, 16'd0, 0, 0, 0, 4);

      @(posedge clk_in);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
